// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the memory-access stage (master) and the data memory (slave).
interface mem_access_ctrl_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [STRB_W-1:0] bus_wstrb_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack bus, formats
// store lanes, extends load data and stalls the pipeline while an access is pending.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                valid_i,
  input  logic [31:0]         alu_res_i,
  input  logic [4:0]          wR_i,
  input  logic                rf_we_i,
  input  logic                mem_re_i,
  input  logic                mem_we_i,
  input  logic [1:0]          mem_size_i,
  input  logic                mem_unsigned_i,
  input  logic [31:0]         store_data_i,
  mem_access_ctrl_if.master   bus,
  output logic [31:0]         wD_o,
  output logic [4:0]          wR_o,
  output logic                rf_we_o,
  output logic                pause_o,
  output logic                err_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [31:0]        r_bus_addr;
  logic [3:0]         r_bus_wstrb;
  logic [31:0]        r_bus_wdata;
  logic [31:0]        r_ldata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_drop;

  logic               w_acc;
  logic               w_mis;
  logic               w_half;
  logic               w_word;
  logic [1:0]         w_off;
  logic [3:0]         w_wstrb;
  logic [31:0]        w_wdata;
  logic [31:0]        w_lext;
  logic [7:0]         w_lbyte;
  logic [15:0]        w_lhalf;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_tmo;

  assign w_acc     = valid_i & (mem_re_i | mem_we_i);
  assign w_off     = alu_res_i[1:0];
  assign w_word    = mem_size_i[1];
  assign w_half    = (mem_size_i == 2'b01);
  assign w_mis     = (w_half & w_off[0]) | (w_word & (w_off != 2'b00));
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_tmo     = (TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT));

  // Store lane formatting: strobes follow the byte offset, data is replicated across lanes.
  always_comb begin
    w_wstrb = 4'h0;
    w_wdata = 32'h0;
    if (mem_we_i) begin
      if (w_word) begin
        w_wstrb = 4'hF;
        w_wdata = store_data_i;
      end else if (w_half) begin
        w_wstrb = 4'b0011 << w_off;
        w_wdata = {2{store_data_i[15:0]}};
      end else begin
        w_wstrb = 4'b0001 << w_off;
        w_wdata = {4{store_data_i[7:0]}};
      end
    end
  end

  // Load extraction and sign/zero extension from the returned word.
  always_comb begin
    w_lbyte = bus.bus_rdata_i[{w_off, 3'b000} +: 8];
    w_lhalf = bus.bus_rdata_i[{w_off[1], 4'b0000} +: 16];
    if (w_word) begin
      w_lext = bus.bus_rdata_i;
    end else if (w_half) begin
      w_lext = mem_unsigned_i ? {16'h0, w_lhalf} : {{16{w_lhalf[15]}}, w_lhalf};
    end else begin
      w_lext = mem_unsigned_i ? {24'h0, w_lbyte} : {{24{w_lbyte[7]}}, w_lbyte};
    end
  end

  // r_drop marks the cycle after a timeout: the held instruction is discarded, not reissued.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wstrb <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_ldata     <= 32'h0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_drop) begin
            r_drop <= 1'b0;
          end else if (w_acc && w_mis) begin
            r_err <= 1'b1;
          end else if (w_acc) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we_i;
            r_bus_addr  <= {alu_res_i[31:2], 2'b00};
            r_bus_wstrb <= w_wstrb;
            r_bus_wdata <= w_wdata;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.bus_ack_i) begin
            r_bus_req <= 1'b0;
            r_ldata   <= w_lext;
            r_cnt     <= '0;
            r_state   <= S_DONE;
          end else if (w_tmo) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_drop    <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write-back and stall outputs toward MEM/WB and upstream stages.
  always_comb begin
    wD_o    = alu_res_i;
    wR_o    = wR_i;
    rf_we_o = 1'b0;
    pause_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_drop) begin
          if (!w_acc) begin
            rf_we_o = valid_i & rf_we_i;
          end else if (!w_mis) begin
            pause_o = rst_n_i;
          end
        end
      end
      S_BUSY: begin
        pause_o = 1'b1;
      end
      S_DONE: begin
        rf_we_o = rf_we_i;
        if (!mem_we_i) begin
          wD_o = r_ldata;
        end
      end
      default: begin
        rf_we_o = 1'b0;
      end
    endcase
  end

  assign bus.bus_req_o   = r_bus_req;
  assign bus.bus_we_o    = r_bus_we;
  assign bus.bus_addr_o  = r_bus_addr;
  assign bus.bus_wstrb_o = r_bus_wstrb;
  assign bus.bus_wdata_o = r_bus_wdata;
  assign err_o           = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4: pass-through, loads, stores,
// misalignment, ack/timeout boundary, timeout abort and asynchronous reset.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic [31:0] alu_res_i;
  logic [4:0]  wR_i;
  logic        rf_we_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [31:0] store_data_i;
  logic [31:0] wD_o;
  logic [4:0]  wR_o;
  logic        rf_we_o;
  logic        pause_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .valid_i        (valid_i),
    .alu_res_i      (alu_res_i),
    .wR_i           (wR_i),
    .rf_we_i        (rf_we_i),
    .mem_re_i       (mem_re_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .store_data_i   (store_data_i),
    .bus            (bus_if),
    .wD_o           (wD_o),
    .wR_o           (wR_o),
    .rf_we_o        (rf_we_o),
    .pause_o        (pause_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic re, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] wr, input logic rfwe);
    valid_i        = v;
    mem_re_i       = re;
    mem_we_i       = we;
    mem_size_i     = sz;
    mem_unsigned_i = uns;
    alu_res_i      = addr;
    store_data_i   = sd;
    wR_i           = wr;
    rf_we_i        = rfwe;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_n_i          = 1'b0;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = 32'h0;
    bubble();
    #1;
    // Reset state and pass-through while in reset
    chk1("rst_req", bus_if.bus_req_o, 1'b0);
    chk1("rst_we", bus_if.bus_we_o, 1'b0);
    chk("rst_addr", bus_if.bus_addr_o, 32'h0);
    chk("rst_wstrb", 32'(bus_if.bus_wstrb_o), 32'h0);
    chk("rst_wdata", bus_if.bus_wdata_o, 32'h0);
    chk1("rst_err", err_o, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 5'd3, 1'b1);
    chk("rst_pass_wD", wD_o, 32'h55);
    chk1("rst_pass_rfwe", rf_we_o, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1);
    chk1("rst_pause", pause_o, 1'b0);
    tick();
    chk1("rst_no_issue", bus_if.bus_req_o, 1'b0);
    bubble();
    rst_n_i = 1'b1;
    tick();

    // Non-memory pass-through, plus a stray ack that must be ignored
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
    bus_if.bus_ack_i = 1'b1;
    chk("np_wD", wD_o, 32'h1234);
    chk("np_wR", 32'(wR_o), 32'd5);
    chk1("np_rfwe", rf_we_o, 1'b1);
    chk1("np_pause", pause_o, 1'b0);
    tick();
    bus_if.bus_ack_i = 1'b0;
    chk1("np_req", bus_if.bus_req_o, 1'b0);
    chk1("np_pause2", pause_o, 1'b0);

    // Word load at 0x100, ack on the 4th BUSY cycle (same cycle the count reaches TIMEOUT)
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1);
    chk1("wl_issue_pause", pause_o, 1'b1);
    chk1("wl_issue_rfwe", rf_we_o, 1'b0);
    tick();
    chk1("wl_req", bus_if.bus_req_o, 1'b1);
    chk("wl_addr", bus_if.bus_addr_o, 32'h100);
    chk1("wl_we", bus_if.bus_we_o, 1'b0);
    chk1("wl_busy_pause", pause_o, 1'b1);
    chk1("wl_busy_rfwe", rf_we_o, 1'b0);
    tick();
    tick();
    chk1("wl_req_hold", bus_if.bus_req_o, 1'b1);
    tick();
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = 32'hDEADBEEF;
    chk1("wl_req_b4", bus_if.bus_req_o, 1'b1);
    tick();
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = 32'h0;
    chk("wl_done_wD", wD_o, 32'hDEADBEEF);
    chk1("wl_done_rfwe", rf_we_o, 1'b1);
    chk("wl_done_wR", 32'(wR_o), 32'd7);
    chk1("wl_done_pause", pause_o, 1'b0);
    chk1("wl_done_req", bus_if.bus_req_o, 1'b0);
    chk1("wl_done_err", err_o, 1'b0);
    bubble();
    tick();

    // Signed then unsigned byte load at 0x103
    for (int u = 0; u < 2; u++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'(u), 32'h103, 32'h0, 5'd9, 1'b1);
      tick();
      chk("bl_addr", bus_if.bus_addr_o, 32'h100);
      bus_if.bus_ack_i   = 1'b1;
      bus_if.bus_rdata_i = 32'h80112233;
      tick();
      bus_if.bus_ack_i   = 1'b0;
      chk("bl_done_wD", wD_o, (u == 0) ? 32'hFFFFFF80 : 32'h00000080);
      bubble();
      tick();
    end

    // Signed half load from the upper half
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 5'd4, 1'b1);
    tick();
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = 32'h9ABC1234;
    tick();
    bus_if.bus_ack_i = 1'b0;
    chk("hl_done_wD", wD_o, 32'hFFFF9ABC);
    bubble();
    tick();

    // Half store 0xABCD at 0x202 with rf_we_i=0
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 5'd2, 1'b0);
    chk1("hs_issue_pause", pause_o, 1'b1);
    tick();
    chk("hs_addr", bus_if.bus_addr_o, 32'h200);
    chk("hs_wstrb", 32'(bus_if.bus_wstrb_o), 32'hC);
    chk("hs_wdata", bus_if.bus_wdata_o, 32'hABCDABCD);
    chk1("hs_we", bus_if.bus_we_o, 1'b1);
    bus_if.bus_ack_i = 1'b1;
    tick();
    bus_if.bus_ack_i = 1'b0;
    chk1("hs_done_rfwe", rf_we_o, 1'b0);
    chk("hs_done_wD", wD_o, 32'h202);
    chk1("hs_done_pause", pause_o, 1'b0);
    bubble();
    tick();

    // Byte store at 0x301 with load also asserted: store wins
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h301, 32'h1234565A, 5'd1, 1'b0);
    tick();
    chk1("bs_we", bus_if.bus_we_o, 1'b1);
    chk("bs_wstrb", 32'(bus_if.bus_wstrb_o), 32'h2);
    chk("bs_wdata", bus_if.bus_wdata_o, 32'h5A5A5A5A);
    bus_if.bus_ack_i = 1'b1;
    tick();
    bus_if.bus_ack_i = 1'b0;
    chk("bs_done_wD", wD_o, 32'h301);
    bubble();
    tick();

    // Misaligned word load at 0x101
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd6, 1'b1);
    chk1("mis_rfwe", rf_we_o, 1'b0);
    chk1("mis_pause", pause_o, 1'b0);
    tick();
    bubble();
    chk1("mis_err", err_o, 1'b1);
    chk1("mis_req", bus_if.bus_req_o, 1'b0);
    tick();
    chk1("mis_err_end", err_o, 1'b0);
    chk1("mis_req2", bus_if.bus_req_o, 1'b0);

    // Timeout: word load at 0x400 with no ack
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd8, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk1("to_req_busy", bus_if.bus_req_o, 1'b1);
      chk1("to_pause_busy", pause_o, 1'b1);
      chk1("to_err_busy", err_o, 1'b0);
    end
    tick();
    chk1("to_req_drop", bus_if.bus_req_o, 1'b0);
    chk1("to_err", err_o, 1'b1);
    chk1("to_pause", pause_o, 1'b0);
    chk1("to_rfwe", rf_we_o, 1'b0);
    bubble();
    tick();
    chk1("to_err_end", err_o, 1'b0);
    chk1("to_no_reissue", bus_if.bus_req_o, 1'b0);

    // Asynchronous reset in the middle of BUSY
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd10, 1'b1);
    tick();
    chk1("ar_req_busy", bus_if.bus_req_o, 1'b1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk1("ar_req", bus_if.bus_req_o, 1'b0);
    chk1("ar_pause", pause_o, 1'b0);
    chk("ar_addr", bus_if.bus_addr_o, 32'h0);
    bubble();
    tick();
    rst_n_i = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'hCAFE0000, 32'h0, 5'd31, 1'b1);
    chk("ar_post_wD", wD_o, 32'hCAFE0000);
    chk1("ar_post_rfwe", rf_we_o, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access stage logic that sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It produces the wD/wR/rf_we values that MEM/WB captures.
- Issues loads and stores to the data bus with a req/ack handshake. Formats store byte lanes and sign- or zero-extends load data.
- Drives the pipeline pause line while a bus access is outstanding.
- Non-memory instructions pass through with zero added latency.

Parameters:
- TIMEOUT, 255, number of BUSY cycles without ack before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  instruction from EX/MEM is valid.
- alu_res_i  in  32  ALU result; this is the byte address for memory ops.
- wR_i  in  5  destination register.
- rf_we_i  in  1  register write enable.
- mem_re_i  in  1  load.
- mem_we_i  in  1  store; takes priority if mem_re_i is also high.
- mem_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- mem_unsigned_i  in  1  zero-extend the load (1) or sign-extend it (0).
- store_data_i  in  32  store operand, right-aligned.
- bus_req_o  out  1  bus request, registered.
- bus_we_o  out  1  bus write, registered.
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}), registered.
- bus_wstrb_o  out  4  byte-lane strobes, registered.
- bus_wdata_o  out  32  lane-replicated store data, registered.
- bus_ack_i  in  1  bus completion; one-cycle pulse.
- bus_rdata_i  in  32  read data, valid with bus_ack_i.
- wD_o  out  32  write-back data toward MEM/WB.
- wR_o  out  5  write-back register toward MEM/WB.
- rf_we_o  out  1  write-back enable toward MEM/WB.
- pause_o  out  1  stall request to the upstream stages and to MEM/WB.
- err_o  out  1  one-cycle pulse on a misaligned access or a timeout.

Behaviour:
- Reset (async, rst_n_i=0), taking effect immediately, including mid-access:
  - state=IDLE.
  - bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o = 0.
  - Load-data register = 0; timeout counter = 0; err_o = 0.
- Combinational outputs during reset: pause_o=0, and wD_o/wR_o/rf_we_o follow the IDLE pass-through rules.
- acc = valid_i & (mem_re_i | mem_we_i).
- mis = (size half & addr[0]) | (size word & addr[1:0]!=0).
- FSM IDLE:
  - Not acc: wD_o=alu_res_i, wR_o=wR_i, rf_we_o=valid_i&rf_we_i, pause_o=0.
  - acc & mis: no bus cycle, err_o<=1 for one cycle, rf_we_o=0, pause_o=0.
  - acc & ~mis: pause_o=1. Register bus_req_o=1, bus_we_o, bus_addr_o, bus_wstrb_o and bus_wdata_o, then go to BUSY.
- FSM BUSY:
  - pause_o=1 and rf_we_o=0; bus outputs are held stable until ack.
  - On bus_ack_i: bus_req_o<=0; store the extended load data; go to DONE.
  - Without ack: the counter increments. When count reaches TIMEOUT, bus_req_o<=0, err_o<=1, go to IDLE with rf_we_o=0. The instruction is dropped because the pipeline advances on the next cycle.
- FSM DONE (lasts 1 cycle):
  - pause_o=0; wR_o=wR_i; rf_we_o=rf_we_i.
  - wD_o = loaded data for a load, alu_res_i for a store.
  - Next state is IDLE, unconditionally.
  - EX/MEM inputs are guaranteed stable from IDLE through DONE because pause holds them.
- Latency: non-memory op 0 extra cycles. Memory op adds 1 cycle for request issue, N wait cycles until ack, and 1 DONE cycle.
- Store formatting, with o = addr[1:0]:
  - Byte: wstrb = 4'b0001<<o, wdata = {4{sd[7:0]}}.
  - Half: wstrb = 4'b0011<<o, wdata = {2{sd[15:0]}}.
  - Word: wstrb = 4'hF, wdata = sd.
- Load extraction:
  - Byte: rdata[8*o +: 8].
  - Half: rdata[16*o[1] +: 16].
  - Word: the full rdata.
  - Extend according to mem_unsigned_i.
- bus_ack_i outside BUSY is ignored.
- An ack on the same cycle the counter reaches TIMEOUT counts as success.

Test Plan:
- Non-memory op, valid=1, rf_we=1, alu_res=0x1234, wR=5 -> same cycle: wD_o=0x1234, wR_o=5, rf_we_o=1, pause_o=0, bus_req_o stays 0.
- Word load at addr 0x100, ack 3 cycles after req, rdata=0xDEADBEEF:
  - bus_addr_o=0x100 and bus_req_o=1 from the cycle after issue.
  - pause_o=1 until DONE.
  - DONE cycle: wD_o=0xDEADBEEF, rf_we_o=1.
- Signed byte load at 0x103 with rdata=0x80112233 -> wD_o=0xFFFFFF80. Repeating it with mem_unsigned_i=1 -> wD_o=0x00000080.
- Half store sd=0xABCD at 0x202:
  - bus_addr_o=0x200, bus_wstrb_o=4'b1100, bus_wdata_o=0xABCDABCD, bus_we_o=1.
  - DONE cycle: rf_we_o=0 when rf_we_i=0.
- Misaligned word load at 0x101 -> err_o pulses for 1 cycle, bus_req_o never rises, rf_we_o=0, pause_o=0.
- TIMEOUT=4 with no ack -> bus_req_o drops after 4 BUSY cycles, err_o pulses, state returns to IDLE. rst_n_i driven low mid-BUSY -> bus_req_o=0 and pause_o=0 immediately.
